// File: rtl/mult_sequencer.sv
// mult_sequencer: multiplies in1 by in2 on the shared calculator datapath
// (MUX1, 4-entry register file, ALU, MUX2) by repeated addition.
// R1 holds in1, R2 holds in2, and R3 accumulates the product. An internal
// W-bit counter, loaded from n_in, sets how many additions are performed.
// All datapath controls are Moore outputs decoded from the current state.
module mult_sequencer #(
  parameter int          W        = 4,
  parameter logic [1:0]  ADD_CODE = 2'b11,
  parameter logic [1:0]  SUB_CODE = 2'b10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic [W-1:0] n_in,
  output logic [1:0]   s1,
  output logic [1:0]   WA,
  output logic         WE,
  output logic [1:0]   RAA,
  output logic         REA,
  output logic [1:0]   RAB,
  output logic         REB,
  output logic [1:0]   C,
  output logic         s2,
  output logic [3:0]   CS,
  output logic         busy,
  output logic         done
);

  // State encodings double as the 7-seg display code on CS.
  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    LOAD_A = 4'd1,
    LOAD_B = 4'd2,
    CLR    = 4'd3,
    ACC    = 4'd4,
    DONE   = 4'd5
  } state_t;

  // MUX1 select codes.
  localparam logic [1:0] SEL_IN1 = 2'b11;
  localparam logic [1:0] SEL_IN2 = 2'b10;
  localparam logic [1:0] SEL_ALU = 2'b00;

  // Register-file addresses used by the algorithm.
  localparam logic [1:0] REG_R1 = 2'b01;
  localparam logic [1:0] REG_R2 = 2'b10;
  localparam logic [1:0] REG_R3 = 2'b11;

  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         go_prev_q, go_prev_d;
  logic         go_rise;

  // A start needs go to have been low on the previous edge, so holding go
  // high through a whole run cannot retrigger a second one.
  assign go_rise = go & ~go_prev_q;

  // State, iteration counter and previous-go register; reset clears all
  // three asynchronously, so the Moore outputs drop to 0 without a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      go_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      go_prev_q <= go_prev_d;
    end
  end

  // Next-state and counter update: the counter is loaded only in LOAD_B and
  // decremented only in ACC, and it is never decremented below zero.
  always_comb begin
    state_d   = IDLE;
    cnt_d     = cnt_q;
    go_prev_d = go;
    case (state_q)
      IDLE: begin
        state_d = go_rise ? LOAD_A : IDLE;
      end
      LOAD_A: begin
        state_d = LOAD_B;
      end
      LOAD_B: begin
        cnt_d   = n_in;
        state_d = CLR;
      end
      CLR: begin
        state_d = (cnt_q != '0) ? ACC : DONE;
      end
      ACC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end
        state_d = (cnt_q > CNT_ONE) ? ACC : DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore decode of the datapath controls; anything not set for a state
  // stays 0, which also covers the unreachable codes 6-15.
  always_comb begin
    s1   = SEL_ALU;
    WA   = 2'b00;
    WE   = 1'b0;
    RAA  = 2'b00;
    REA  = 1'b0;
    RAB  = 2'b00;
    REB  = 1'b0;
    C    = 2'b00;
    s2   = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    CS   = state_q;
    case (state_q)
      IDLE: begin
        CS = 4'd0;
      end
      LOAD_A: begin
        s1   = SEL_IN1;
        WA   = REG_R1;
        WE   = 1'b1;
        busy = 1'b1;
      end
      LOAD_B: begin
        s1   = SEL_IN2;
        WA   = REG_R2;
        WE   = 1'b1;
        busy = 1'b1;
      end
      CLR: begin
        s1   = SEL_ALU;
        WA   = REG_R3;
        WE   = 1'b1;
        RAA  = REG_R1;
        REA  = 1'b1;
        RAB  = REG_R1;
        REB  = 1'b1;
        C    = SUB_CODE;
        busy = 1'b1;
      end
      ACC: begin
        s1   = SEL_ALU;
        WA   = REG_R3;
        WE   = 1'b1;
        RAA  = REG_R3;
        REA  = 1'b1;
        RAB  = REG_R1;
        REB  = 1'b1;
        C    = ADD_CODE;
        busy = 1'b1;
      end
      DONE: begin
        RAA  = REG_R3;
        REA  = 1'b1;
        s2   = 1'b1;
        done = 1'b1;
        busy = 1'b1;
      end
      default: begin
        CS = 4'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Testbench for mult_sequencer: directed runs push the expected per-cycle
// control vectors into a queue; a monitor compares each busy cycle.
module tb_mult_sequencer;

  localparam int W = 4;

  typedef struct packed {
    logic [3:0] cs;
    logic [1:0] s1;
    logic [1:0] wa;
    logic       we;
    logic [1:0] raa;
    logic       rea;
    logic [1:0] rab;
    logic       reb;
    logic [1:0] c;
    logic       s2;
    logic       busy;
    logic       done;
  } ctl_t;

  logic         clk;
  logic         rst;
  logic         go;
  logic [W-1:0] n_in;
  logic [1:0]   s1, WA, RAA, RAB, C;
  logic         WE, REA, REB, s2, busy, done;
  logic [3:0]   CS;

  ctl_t exp_q[$];
  int   tests_run;
  int   fails;
  int   cyc;
  int   done_cyc;

  mult_sequencer #(.W(W), .ADD_CODE(2'b11), .SUB_CODE(2'b10)) dut (
    .clk  (clk),
    .rst  (rst),
    .go   (go),
    .n_in (n_in),
    .s1   (s1),
    .WA   (WA),
    .WE   (WE),
    .RAA  (RAA),
    .REA  (REA),
    .RAB  (RAB),
    .REB  (REB),
    .C    (C),
    .s2   (s2),
    .CS   (CS),
    .busy (busy),
    .done (done)
  );

  // 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Rising-edge counter used for the go-to-DONE latency check.
  always @(posedge clk) cyc++;

  // Hand-written control table, one entry per state code.
  function automatic ctl_t expFor(input int code);
    ctl_t e;
    e = '0;
    case (code)
      1: begin e.cs = 4'd1; e.s1 = 2'b11; e.wa = 2'b01; e.we = 1'b1; e.busy = 1'b1; end
      2: begin e.cs = 4'd2; e.s1 = 2'b10; e.wa = 2'b10; e.we = 1'b1; e.busy = 1'b1; end
      3: begin e.cs = 4'd3; e.s1 = 2'b00; e.wa = 2'b11; e.we = 1'b1;
               e.raa = 2'b01; e.rea = 1'b1; e.rab = 2'b01; e.reb = 1'b1;
               e.c = 2'b10; e.busy = 1'b1; end
      4: begin e.cs = 4'd4; e.s1 = 2'b00; e.wa = 2'b11; e.we = 1'b1;
               e.raa = 2'b11; e.rea = 1'b1; e.rab = 2'b01; e.reb = 1'b1;
               e.c = 2'b11; e.busy = 1'b1; end
      5: begin e.cs = 4'd5; e.raa = 2'b11; e.rea = 1'b1; e.s2 = 1'b1;
               e.done = 1'b1; e.busy = 1'b1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic ctl_t sampleDut();
    ctl_t a;
    a.cs = CS;  a.s1 = s1;  a.wa = WA;  a.we = WE;
    a.raa = RAA; a.rea = REA; a.rab = RAB; a.reb = REB;
    a.c = C;    a.s2 = s2;  a.busy = busy; a.done = done;
    return a;
  endfunction

  // Monitor: every busy cycle must match the next queued expectation.
  always @(negedge clk) begin
    ctl_t act;
    ctl_t e;
    if (rst === 1'b1 && busy === 1'b1) begin
      act = sampleDut();
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_busy: got %h, required no busy cycle", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          fails++;
          $display("[TB] FAIL seq_cs%0d: got %h, required %h", e.cs, act, e);
        end
        if (act.done === 1'b1) done_cyc = cyc;
      end
    end
  end

  task automatic checkOutput(input ctl_t e, input string name);
    ctl_t act;
    act = sampleDut();
    tests_run++;
    if (act !== e) begin
      fails++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, e);
    end
  endtask

  task automatic checkDrained(input string name);
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL %s: %0d expected cycles never seen, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic pushRun(input int n, input int acc_seen, input bit full);
    exp_q.push_back(expFor(1));
    exp_q.push_back(expFor(2));
    exp_q.push_back(expFor(3));
    for (int i = 0; i < (full ? n : acc_seen); i++) exp_q.push_back(expFor(4));
    if (full) exp_q.push_back(expFor(5));
  endtask

  // One complete run: go edge, drain expectations, then latency and IDLE.
  task automatic applyStimulus(input int n, input bit hold_go, input int exp_lat);
    int start_cyc;
    int budget;
    @(negedge clk);
    n_in = W'(n);
    pushRun(n, 0, 1'b1);
    start_cyc = cyc;
    done_cyc  = -1;
    go = 1'b1;
    @(negedge clk);
    if (!hold_go) go = 1'b0;
    budget = n + 12;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    checkDrained($sformatf("drain_n%0d", n));
    tests_run++;
    if (done_cyc - start_cyc != exp_lat) begin
      fails++;
      $display("[TB] FAIL latency_n%0d: got %0d, required %0d", n, done_cyc - start_cyc, exp_lat);
    end
    @(negedge clk);
    #1;
    checkOutput(expFor(0), $sformatf("idle_after_n%0d", n));
  endtask

  initial begin
    tests_run = 0;
    fails     = 0;
    cyc       = 0;
    done_cyc  = -1;
    rst  = 1'b0;
    go   = 1'b0;
    n_in = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    checkOutput(expFor(0), "reset_state");
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput(expFor(0), "idle_after_release");

    // Asynchronous reset in the middle of LOAD_B, checked before any edge.
    @(negedge clk);
    n_in = 4'd3;
    exp_q.push_back(expFor(1));
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checkOutput(expFor(0), "async_reset_mid_loadb");
    checkDrained("pre_reset_loada");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checkOutput(expFor(0), "idle_hold_go0");
    end

    // Regular runs: n=3, n=0 (skips ACC), n=15 (max count).
    applyStimulus(3, 1'b0, 7);
    applyStimulus(0, 1'b0, 4);
    applyStimulus(15, 1'b0, 19);

    // go held high through a run must not retrigger.
    applyStimulus(2, 1'b1, 6);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checkOutput(expFor(0), "no_restart_go_held");
    end
    go = 1'b0;
    applyStimulus(2, 1'b0, 6);

    // Reset during the second ACC of an n=5 run, then a clean n=5 run.
    @(negedge clk);
    n_in = 4'd5;
    pushRun(5, 2, 1'b0);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checkDrained("pre_reset_acc2");
    #1;
    rst = 1'b0;
    #1;
    checkOutput(expFor(0), "async_reset_mid_acc");
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(5, 1'b0, 9);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
